multicycle_control: RTL and testbench

- Main control FSM for the multicycle LEGv8 datapath; sits directly upstream of the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives ALUOp (00 = add, 01 = pass-B / CBZ test, 10 = decode from opcode) plus every datapath strobe and mux select.
- Stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/multicycle_control.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle LEGv8 datapath.
// Each instruction is stepped through fetch, decode, execute, memory and
// writeback states. The FSM drives ALUOp for the downstream ALU control
// decoder, plus every datapath strobe and mux select. It also keeps a count
// of retired instructions.
//
// Memory handshake: the FSM holds a request (MemRead in FETCH/MEMREAD,
// MemWrite in MEMWRITE) steady. The access completes in the cycle where
// mem_ready is high. mem_ready is ignored in every other state.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   OpCode[10:0]      instruction bits [31:21] from the IR
//   mem_ready         memory access completes this cycle
//   ALUOp[1:0]        00 add, 01 pass-B (CBZ), 10 decode from opcode
//   ALUSrcA, ALUSrcB  ALU operand selects
//   PCSource          PC next-value select
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegWrite, Reg2Loc   datapath strobes / selects
//   state[3:0]        current state code (debug)
//   illegal           unknown opcode flag
//   retired[CNT_W-1:0] retired-instruction count (wraps)
//
// Optional feature macro ILLEGAL_TRAP_EN:
//   defined   - an illegal opcode parks the FSM in TRAP until reset, with
//               illegal held high.
//   undefined - an illegal opcode is treated as a NOP. illegal pulses for
//               the DECODE cycle only.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      OpCode,
  input  logic             mem_ready,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             Reg2Loc,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_CBZ      = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // Moore part of the outputs, registered alongside the state.
  // The fetch bit marks FETCH, where PCWrite/IRWrite wait on mem_ready.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       fetch;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg2loc;
  } ctl_t;

  state_t state_q, state_next;
  ctl_t   ctl_q;
  logic   is_ldur, is_stur, is_rtype, is_addi, is_cbz, is_b, is_bad;
  logic   retire_now;

  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.fetch = 1'b1; end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMREAD:  begin c.mem_read = 1'b1; c.ior_d = 1'b1; end
      S_MEMWB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWRITE: begin c.mem_write = 1'b1; c.ior_d = 1'b1; c.reg2loc = 1'b1; end
      S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_EXEC_I:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b10; end
      S_ALUWB:    c.reg_write = 1'b1;
      S_CBZ:      begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.reg2loc       = 1'b1;
      end
      S_BRANCH:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Opcode classes. The IR is stable from DECODE until the next FETCH, so
  // the FSM may also sample these in later states (e.g. MEMADR).
  always_comb begin
    is_ldur  = (OpCode == 11'd1986);
    is_stur  = (OpCode == 11'd1984);
    is_rtype = (OpCode == 11'd1112) || (OpCode == 11'd1624) ||
               (OpCode == 11'd1104) || (OpCode == 11'd1360);
    is_addi  = (OpCode[10:1] == 10'd580);
    is_cbz   = (OpCode[10:3] == 8'd180);
    is_b     = (OpCode[10:5] == 6'd5);
    is_bad   = !(is_ldur || is_stur || is_rtype || is_addi || is_cbz || is_b);
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (is_ldur || is_stur) state_next = S_MEMADR;
        else if (is_rtype)      state_next = S_EXEC_R;
        else if (is_addi)       state_next = S_EXEC_I;
        else if (is_cbz)        state_next = S_CBZ;
        else if (is_b)          state_next = S_BRANCH;
        else
`ifdef ILLEGAL_TRAP_EN
                                state_next = S_TRAP;
`else
                                state_next = S_FETCH;
`endif
      end
      S_MEMADR:   state_next = is_ldur ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXEC_R:   state_next = S_ALUWB;
      S_EXEC_I:   state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_CBZ:      state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_next = S_TRAP;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  // An instruction retires on any return to FETCH, except from DECODE.
  // That path is the illegal-opcode NOP, which does not count.
  assign retire_now = (state_next == S_FETCH) && (state_q != S_FETCH) &&
                      (state_q != S_DECODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctl_q   <= decode_ctl(S_FETCH);
      retired <= '0;
    end else begin
      state_q <= state_next;
      ctl_q   <= decode_ctl(state_next);
      if (retire_now) retired <= retired + CNT_W'(1);
    end
  end

  // Reset forces every output to 0 within the same cycle. This abandons an
  // in-flight access without a partial write.
  always_comb begin
    ALUOp       = '0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = '0;
    PCSource    = '0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    Reg2Loc     = 1'b0;
    illegal     = 1'b0;
    if (!reset) begin
      ALUOp       = ctl_q.alu_op;
      ALUSrcA     = ctl_q.alu_src_a;
      ALUSrcB     = ctl_q.alu_src_b;
      PCSource    = ctl_q.pc_source;
      PCWrite     = ctl_q.pc_write | (ctl_q.fetch & mem_ready);
      PCWriteCond = ctl_q.pc_write_cond;
      IorD        = ctl_q.ior_d;
      MemRead     = ctl_q.mem_read;
      MemWrite    = ctl_q.mem_write;
      IRWrite     = ctl_q.fetch & mem_ready;
      MemtoReg    = ctl_q.mem_to_reg;
      RegWrite    = ctl_q.reg_write;
      Reg2Loc     = ctl_q.reg2loc | ((state_q == S_DECODE) && (is_stur || is_cbz));
      illegal     = ((state_q == S_DECODE) && is_bad) || (state_q == S_TRAP);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (default build, trap disabled).
module tb_multicycle_control;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset, mem_ready;
  logic [10:0]      OpCode;
  logic [1:0]       ALUOp, ALUSrcB, PCSource;
  logic             ALUSrcA, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic             IRWrite, MemtoReg, RegWrite, Reg2Loc, illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Reg2Loc(Reg2Loc),
    .state(state), .illegal(illegal), .retired(retired)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [CNT_W-1:0] ret_exp = '0;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_write, pc_wc, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg2loc, illegal;
  } ctl_t;

  typedef struct {
    logic [10:0] op;
    int          path[6];
    int          n;
    bit          legal;
  } vec_t;

  vec_t tbl[15];
  int   rp[$];

  // instruction class: 0 illegal, 1 LDUR, 2 STUR, 3 R-type, 4 ADDI, 5 CBZ, 6 B
  function automatic int cls(input logic [10:0] op);
    int v;
    v = int'(op);
    if (v == 1986) return 1;
    if (v == 1984) return 2;
    if (v == 1112 || v == 1624 || v == 1104 || v == 1360) return 3;
    if (v / 2 == 580) return 4;
    if (v / 8 == 180) return 5;
    if (v / 32 == 5) return 6;
    return 0;
  endfunction

  // expected outputs for a given state code, straight from the state table
  function automatic ctl_t exp_ctl(input int s, input logic r, input logic mr,
                                   input logic [10:0] op);
    ctl_t c;
    int   k;
    c = '0;
    k = cls(op);
    if (r) return c;
    case (s)
      0:  begin c.mem_read = 1; c.src_b = 2'b01; c.pc_write = mr; c.ir_write = mr; end
      1:  begin c.src_b = 2'b11; c.reg2loc = (k == 2 || k == 5); c.illegal = (k == 0); end
      2:  begin c.src_a = 1; c.src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; c.reg2loc = 1; end
      6:  begin c.src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.src_a = 1; c.src_b = 2'b10; c.alu_op = 2'b10; end
      8:  c.reg_write = 1;
      9:  begin c.src_a = 1; c.alu_op = 2'b01; c.pc_wc = 1; c.pc_src = 2'b01; c.reg2loc = 1; end
      10: begin c.pc_write = 1; c.pc_src = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // reference path of state codes for one instruction
  task automatic path_of(input logic [10:0] op);
    case (cls(op))
      1:       rp = '{0, 1, 2, 3, 4};
      2:       rp = '{0, 1, 2, 5};
      3:       rp = '{0, 1, 6, 8};
      4:       rp = '{0, 1, 7, 8};
      5:       rp = '{0, 1, 9};
      6:       rp = '{0, 1, 10};
      default: rp = '{0, 1};
    endcase
  endtask

  function automatic bit is_wait(input int s);
    return (s == 0 || s == 3 || s == 5);
  endfunction

  // scoreboard comparison
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // driver: apply inputs just after a posedge, check outputs at the negedge.
  // es < 0 skips the state check; chk_ret selects the retired check.
  task automatic step(input logic r, input logic mr, input logic [10:0] op,
                      input int es, input bit chk_ret, input string tag);
    ctl_t got, want;
    reset = r; mem_ready = mr; OpCode = op;
    @(negedge clk);
    got = {ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
           MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, Reg2Loc, illegal};
    want = exp_ctl(es, r, mr, op);
    chk($sformatf("%s ctl s=%0d", tag, es), 32'(got), 32'(want));
    if (es >= 0) chk($sformatf("%s state", tag), 32'(state), 32'(es));
    if (chk_ret) chk($sformatf("%s retired", tag), retired, ret_exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] op;
    logic        mr;
    int          c, idx, guard;

    tbl[0]  = '{11'd1112, '{0, 1, 6, 8, 0, 0}, 4, 1'b1};
    tbl[1]  = '{11'd1624, '{0, 1, 6, 8, 0, 0}, 4, 1'b1};
    tbl[2]  = '{11'd1104, '{0, 1, 6, 8, 0, 0}, 4, 1'b1};
    tbl[3]  = '{11'd1360, '{0, 1, 6, 8, 0, 0}, 4, 1'b1};
    tbl[4]  = '{11'd1160, '{0, 1, 7, 8, 0, 0}, 4, 1'b1};
    tbl[5]  = '{11'd1161, '{0, 1, 7, 8, 0, 0}, 4, 1'b1};
    tbl[6]  = '{11'd1986, '{0, 1, 2, 3, 4, 0}, 5, 1'b1};
    tbl[7]  = '{11'd1984, '{0, 1, 2, 5, 0, 0}, 4, 1'b1};
    tbl[8]  = '{11'd1444, '{0, 1, 9, 0, 0, 0}, 3, 1'b1};
    tbl[9]  = '{11'd160,  '{0, 1, 10, 0, 0, 0}, 3, 1'b1};
    tbl[10] = '{11'd191,  '{0, 1, 10, 0, 0, 0}, 3, 1'b1};
    tbl[11] = '{11'd1447, '{0, 1, 9, 0, 0, 0}, 3, 1'b1};
    tbl[12] = '{11'd0,    '{0, 1, 0, 0, 0, 0}, 2, 1'b0};
    tbl[13] = '{11'd1985, '{0, 1, 0, 0, 0, 0}, 2, 1'b0};
    tbl[14] = '{11'd1162, '{0, 1, 0, 0, 0, 0}, 2, 1'b0};

    // reset held two cycles; outputs must be all zero
    step(1'b1, 1'b1, 11'd0, -1, 1'b0, "rst0");
    step(1'b1, 1'b1, 11'd0, 0, 1'b1, "rst1");

    // table-driven: every class, zero wait states
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++)
        step(1'b0, 1'b1, tbl[i].op, tbl[i].path[k], 1'b1, $sformatf("tbl%0d", i));
      if (tbl[i].legal) ret_exp++;
    end
    chk("retired_after_table", retired, 32'd12);

    // LDUR with three wait cycles in MEMREAD; mem_ready is don't-care elsewhere
    op = 11'd1986;
    step(1'b0, 1'b1, op, 0, 1'b1, "ldw");
    step(1'b0, 1'($urandom_range(0, 1)), op, 1, 1'b1, "ldw");
    step(1'b0, 1'($urandom_range(0, 1)), op, 2, 1'b1, "ldw");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, op, 3, 1'b1, "ldw");
    step(1'b0, 1'b1, op, 3, 1'b1, "ldw");
    step(1'b0, 1'($urandom_range(0, 1)), op, 4, 1'b1, "ldw");
    ret_exp++;

    // FETCH stall: MemRead stays up, PCWrite/IRWrite wait for mem_ready
    op = 11'd1112;
    step(1'b0, 1'b0, op, 0, 1'b1, "fstall");
    step(1'b0, 1'b0, op, 0, 1'b1, "fstall");
    step(1'b0, 1'b1, op, 0, 1'b1, "fstall");
    step(1'b0, 1'b1, op, 1, 1'b1, "fstall");
    step(1'b0, 1'b1, op, 6, 1'b1, "fstall");
    step(1'b0, 1'b1, op, 8, 1'b1, "fstall");
    ret_exp++;

    // randomized instructions and mem_ready against the path model
    for (int i = 0; i < 150; i++) begin
      c = $urandom_range(0, 7);
      case (c)
        0: op = 11'd1986;
        1: op = 11'd1984;
        2: begin
          idx = $urandom_range(0, 3);
          op = (idx == 0) ? 11'd1112 : (idx == 1) ? 11'd1624 :
               (idx == 2) ? 11'd1104 : 11'd1360;
        end
        3: op = 11'd1160 + 11'($urandom_range(0, 1));
        4: op = 11'd1440 + 11'($urandom_range(0, 7));
        5: op = 11'd160 + 11'($urandom_range(0, 31));
        default: begin
          op = 11'($urandom_range(0, 2047));
          while (cls(op) != 0) op = 11'($urandom_range(0, 2047));
        end
      endcase
      path_of(op);
      idx = 0;
      guard = 0;
      while (idx < rp.size() && guard < 200) begin
        mr = ($urandom_range(0, 3) != 0);
        step(1'b0, mr, op, rp[idx], 1'b1, "rnd");
        if (!(is_wait(rp[idx]) && !mr)) idx++;
        guard++;
      end
      if (idx < rp.size()) begin
        total++;
        bad++;
        $display("FAIL rnd_budget: got=%0d want=%0d", idx, rp.size());
      end
      if (cls(op) != 0) ret_exp++;
    end

    // reset while MEMWRITE is stalled: no write in the reset cycle
    op = 11'd1984;
    step(1'b0, 1'b1, op, 0, 1'b1, "rstmw");
    step(1'b0, 1'b1, op, 1, 1'b1, "rstmw");
    step(1'b0, 1'b1, op, 2, 1'b1, "rstmw");
    step(1'b0, 1'b0, op, 5, 1'b1, "rstmw");
    step(1'b0, 1'b0, op, 5, 1'b1, "rstmw");
    step(1'b1, 1'b0, op, -1, 1'b1, "rstmw_rst");
    ret_exp = '0;
    step(1'b0, 1'b0, op, 0, 1'b1, "rstmw_after");
    step(1'b0, 1'b1, op, 0, 1'b1, "rstmw_after");
    step(1'b0, 1'b1, op, 1, 1'b1, "rstmw_after");
    step(1'b0, 1'b1, op, 2, 1'b1, "rstmw_after");
    step(1'b0, 1'b1, op, 5, 1'b1, "rstmw_after");
    ret_exp++;
    chk("retired_final", retired, ret_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
